output_pattern_monitor: RTL and testbench



---
 rtl/evr_monitor_pkg.sv | 29 ++
 rtl/pattern_word_analyzer.sv | 79 +++++++
 rtl/output_pattern_monitor.sv | 221 ++++++++++++++++++++++
 tb/tb_output_pattern_monitor.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evr_monitor_pkg.sv
// -----------------------------------------------------------------------------
// evr_monitor_pkg
//
// Shared definitions for the EVR output pattern monitor:
//   - monitor_state_e : capture sequencer states (IDLE/ARMED/CAPTURE/DONE)
//   - bit_index_width : width of a bit index inside the capture window
//   - default geometry of the monitor (4-bit SERDES words, 64-word window)
//
// Ports: none (package).
// -----------------------------------------------------------------------------
package evr_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } monitor_state_e;

  localparam int DEFAULT_SERDES_WIDTH          = 4;
  localparam int DEFAULT_CAPTURE_ADDRESS_WIDTH = 6;

  // A bit index is a word address concatenated with a bit position.
  function automatic int bit_index_width(input int capture_address_width,
                                         input int serdes_width);
    return capture_address_width + $clog2(serdes_width);
  endfunction

endpackage

// File: rtl/pattern_word_analyzer.sv
// -----------------------------------------------------------------------------
// pattern_word_analyzer
//
// Purely combinational analysis of one SERDES word. Bit 0 is earliest in time;
// bit 0 is preceded by prev_msb (the last bit of the previous word).
//
// Ports:
//   word                in  SERDES_WIDTH   pattern word
//   prev_msb            in  1              bit preceding bit 0
//   rise_valid          out 1              word contains at least one rising edge
//   rise_pos            out POS_WIDTH      bit position of the earliest rising edge
//   rise_count          out COUNT_WIDTH    number of rising edges in the word
//   ones_from_rise      out COUNT_WIDTH    length of the 1-run starting at rise_pos
//   all_ones_after_rise out 1              that run reaches the MSB of the word
//   lead_ones           out COUNT_WIDTH    length of the 1-run starting at bit 0
// -----------------------------------------------------------------------------
module pattern_word_analyzer #(
  parameter  int SERDES_WIDTH = 4,
  localparam int POS_WIDTH    = $clog2(SERDES_WIDTH),
  localparam int COUNT_WIDTH  = $clog2(SERDES_WIDTH) + 1
) (
  input  logic [SERDES_WIDTH-1:0] word,
  input  logic                    prev_msb,
  output logic                    rise_valid,
  output logic [POS_WIDTH-1:0]    rise_pos,
  output logic [COUNT_WIDTH-1:0]  rise_count,
  output logic [COUNT_WIDTH-1:0]  ones_from_rise,
  output logic                    all_ones_after_rise,
  output logic [COUNT_WIDTH-1:0]  lead_ones
);

  logic [SERDES_WIDTH:0]   history;
  logic [SERDES_WIDTH-1:0] rise_bits;
  logic                    in_rise_run;
  logic                    in_lead_run;

  // history[b+1] is bit b of the word, history[b] the bit before it in time.
  assign history   = {word, prev_msb};
  assign rise_bits = history[SERDES_WIDTH:1] & ~history[SERDES_WIDTH-1:0];

  // Single LSB-to-MSB scan: the first rise opens a run that is followed until
  // the first 0; the leading run from bit 0 is tracked independently so the
  // caller can extend a pulse that started in an earlier word.
  always_comb begin
    rise_valid     = 1'b0;
    rise_pos       = '0;
    rise_count     = '0;
    ones_from_rise = '0;
    lead_ones      = '0;
    in_rise_run    = 1'b0;
    in_lead_run    = 1'b1;
    for (int b = 0; b < SERDES_WIDTH; b++) begin
      if (rise_bits[b]) begin
        rise_count = rise_count + 1'b1;
      end
      if (!rise_valid && rise_bits[b]) begin
        rise_valid  = 1'b1;
        rise_pos    = b[POS_WIDTH-1:0];
        in_rise_run = 1'b1;
      end
      if (in_rise_run) begin
        if (word[b]) begin
          ones_from_rise = ones_from_rise + 1'b1;
        end else begin
          in_rise_run = 1'b0;
        end
      end
      if (in_lead_run) begin
        if (word[b]) begin
          lead_ones = lead_ones + 1'b1;
        end else begin
          in_lead_run = 1'b0;
        end
      end
    end
    all_ones_after_rise = in_rise_run;
  end

endmodule

// File: rtl/output_pattern_monitor.sv
// -----------------------------------------------------------------------------
// output_pattern_monitor
//
// Captures a window of 2^CAPTURE_ADDRESS_WIDTH SERDES words starting at a
// trigger, measures first-edge delay, first-pulse width and rising-edge count
// in bit units, and keeps the raw words in a readable buffer.
//
// Ports:
//   evrClk          in  1                      sole clock
//   evrRst_n        in  1                      asynchronous active-low reset
//   armStrobe       in  1                      arm / re-arm (clears results)
//   triggerStrobe   in  1                      opens the window while armed
//   serdesPattern   in  SERDES_WIDTH           one word per cycle, bit 0 first
//   captureAddress  in  CAPTURE_ADDRESS_WIDTH  buffer read address
//   captureData     out SERDES_WIDTH           registered buffer word
//   busy            out 1                      armed or capturing
//   done            out 1                      results valid
//   edgeFound       out 1                      a rising edge was seen
//   firstEdge       out BIT_INDEX_WIDTH        bit index of the first rise
//   pulseWidth      out BIT_INDEX_WIDTH+1      length of the first high run
//   widthOpen       out 1                      first run still high at window end
//   edgeCount       out BIT_INDEX_WIDTH        rising edges, saturating
// -----------------------------------------------------------------------------
module output_pattern_monitor
  import evr_monitor_pkg::*;
#(
  parameter  int SERDES_WIDTH          = DEFAULT_SERDES_WIDTH,
  parameter  int CAPTURE_ADDRESS_WIDTH = DEFAULT_CAPTURE_ADDRESS_WIDTH,
  localparam int BIT_INDEX_WIDTH       = bit_index_width(CAPTURE_ADDRESS_WIDTH, SERDES_WIDTH)
) (
  input  logic                             evrClk,
  input  logic                             evrRst_n,
  input  logic                             armStrobe,
  input  logic                             triggerStrobe,
  input  logic [SERDES_WIDTH-1:0]          serdesPattern,
  input  logic [CAPTURE_ADDRESS_WIDTH-1:0] captureAddress,
  output logic [SERDES_WIDTH-1:0]          captureData,
  output logic                             busy,
  output logic                             done,
  output logic                             edgeFound,
  output logic [BIT_INDEX_WIDTH-1:0]       firstEdge,
  output logic [BIT_INDEX_WIDTH:0]         pulseWidth,
  output logic                             widthOpen,
  output logic [BIT_INDEX_WIDTH-1:0]       edgeCount
);

  localparam int POS_WIDTH        = $clog2(SERDES_WIDTH);
  localparam int COUNT_WIDTH      = $clog2(SERDES_WIDTH) + 1;
  localparam int PULSE_WIDTH_BITS = BIT_INDEX_WIDTH + 1;
  localparam int DEPTH            = 1 << CAPTURE_ADDRESS_WIDTH;

  localparam logic [BIT_INDEX_WIDTH-1:0]       NO_EDGE_INDEX  = '1;
  localparam logic [BIT_INDEX_WIDTH-1:0]       EDGE_COUNT_MAX = '1;
  localparam logic [CAPTURE_ADDRESS_WIDTH-1:0] LAST_WORD      = '1;
  localparam logic [COUNT_WIDTH-1:0]           FULL_WORD_RUN  = COUNT_WIDTH'(SERDES_WIDTH);

  monitor_state_e                   state_q, state_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic                             edge_found_q, edge_found_d;
  logic [BIT_INDEX_WIDTH-1:0]       first_edge_q, first_edge_d;
  logic [BIT_INDEX_WIDTH:0]         pulse_width_q, pulse_width_d;
  logic                             width_open_q, width_open_d;
  logic [BIT_INDEX_WIDTH-1:0]       edge_count_q, edge_count_d;
  logic [CAPTURE_ADDRESS_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic                             prev_msb_q, prev_msb_d;
  logic                             run_open_q, run_open_d;
  logic [SERDES_WIDTH-1:0]          capture_data_q, capture_data_d;

  logic                             capture_active;
  logic [CAPTURE_ADDRESS_WIDTH-1:0] word_index;
  logic                             analyzer_prev_msb;
  logic                             rise_valid;
  logic [POS_WIDTH-1:0]             rise_pos;
  logic [COUNT_WIDTH-1:0]           rise_count;
  logic [COUNT_WIDTH-1:0]           ones_from_rise;
  logic                             all_ones_after_rise;
  logic [COUNT_WIDTH-1:0]           lead_ones;
  logic [BIT_INDEX_WIDTH:0]         edge_sum;

  logic [SERDES_WIDTH-1:0]          capture_mem [DEPTH];

  // The trigger cycle itself is capture cycle 0, so a word is consumed either
  // in ARMED with a trigger or in CAPTURE. An arm in the same cycle always wins.
  assign capture_active = !armStrobe &&
                          ((state_q == ST_ARMED && triggerStrobe) || state_q == ST_CAPTURE);

  // Word 0 has no predecessor in the window; its preceding bit counts as 0.
  assign word_index        = (state_q == ST_CAPTURE) ? word_cnt_q : '0;
  assign analyzer_prev_msb = (state_q == ST_CAPTURE) ? prev_msb_q : 1'b0;

  pattern_word_analyzer #(
    .SERDES_WIDTH(SERDES_WIDTH)
  ) u_word_analyzer (
    .word               (serdesPattern),
    .prev_msb           (analyzer_prev_msb),
    .rise_valid         (rise_valid),
    .rise_pos           (rise_pos),
    .rise_count         (rise_count),
    .ones_from_rise     (ones_from_rise),
    .all_ones_after_rise(all_ones_after_rise),
    .lead_ones          (lead_ones)
  );

  // One extra bit so the carry out signals saturation.
  assign edge_sum = {1'b0, edge_count_q} + PULSE_WIDTH_BITS'(rise_count);

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = done_q;
    edge_found_d  = edge_found_q;
    first_edge_d  = first_edge_q;
    pulse_width_d = pulse_width_q;
    width_open_d  = width_open_q;
    edge_count_d  = edge_count_q;
    word_cnt_d    = word_cnt_q;
    prev_msb_d    = prev_msb_q;
    run_open_d    = run_open_q;

    if (armStrobe) begin
      state_d       = ST_ARMED;
      busy_d        = 1'b1;
      done_d        = 1'b0;
      edge_found_d  = 1'b0;
      first_edge_d  = '0;
      pulse_width_d = '0;
      width_open_d  = 1'b0;
      edge_count_d  = '0;
      word_cnt_d    = '0;
      prev_msb_d    = 1'b0;
      run_open_d    = 1'b0;
    end else if (capture_active) begin
      state_d      = ST_CAPTURE;
      word_cnt_d   = word_index + 1'b1;
      prev_msb_d   = serdesPattern[SERDES_WIDTH-1];
      edge_count_d = edge_sum[BIT_INDEX_WIDTH] ? EDGE_COUNT_MAX
                                               : edge_sum[BIT_INDEX_WIDTH-1:0];

      // run_open tracks whether the first pulse is still high at the end of
      // the current word, so the next word only has to add its leading 1s.
      if (!edge_found_q) begin
        if (rise_valid) begin
          edge_found_d  = 1'b1;
          first_edge_d  = {word_index, rise_pos};
          pulse_width_d = PULSE_WIDTH_BITS'(ones_from_rise);
          run_open_d    = all_ones_after_rise;
        end
      end else if (run_open_q) begin
        pulse_width_d = pulse_width_q + PULSE_WIDTH_BITS'(lead_ones);
        run_open_d    = (lead_ones == FULL_WORD_RUN);
      end

      if (word_index == LAST_WORD) begin
        state_d      = ST_DONE;
        busy_d       = 1'b0;
        done_d       = 1'b1;
        width_open_d = run_open_d;
        if (!edge_found_d) begin
          first_edge_d  = NO_EDGE_INDEX;
          pulse_width_d = '0;
        end
      end
    end
  end

  always_ff @(posedge evrClk or negedge evrRst_n) begin
    if (!evrRst_n) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      edge_found_q  <= 1'b0;
      first_edge_q  <= '0;
      pulse_width_q <= '0;
      width_open_q  <= 1'b0;
      edge_count_q  <= '0;
      word_cnt_q    <= '0;
      prev_msb_q    <= 1'b0;
      run_open_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      edge_found_q  <= edge_found_d;
      first_edge_q  <= first_edge_d;
      pulse_width_q <= pulse_width_d;
      width_open_q  <= width_open_d;
      edge_count_q  <= edge_count_d;
      word_cnt_q    <= word_cnt_d;
      prev_msb_q    <= prev_msb_d;
      run_open_q    <= run_open_d;
    end
  end

  // Capture buffer: simple dual-port RAM without reset so it maps to block RAM.
  always_ff @(posedge evrClk) begin
    if (capture_active) begin
      capture_mem[word_index] <= serdesPattern;
    end
  end

  assign capture_data_d = capture_mem[captureAddress];

  always_ff @(posedge evrClk or negedge evrRst_n) begin
    if (!evrRst_n) begin
      capture_data_q <= '0;
    end else begin
      capture_data_q <= capture_data_d;
    end
  end

  assign captureData = capture_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign edgeFound   = edge_found_q;
  assign firstEdge   = first_edge_q;
  assign pulseWidth  = pulse_width_q;
  assign widthOpen   = width_open_q;
  assign edgeCount   = edge_count_q;

endmodule

// File: tb/tb_output_pattern_monitor.sv
// -----------------------------------------------------------------------------
// tb_output_pattern_monitor
//
// Self-checking bench for output_pattern_monitor (4-bit words, 64-word window).
// A window-level model records the captured words and evaluates the results by
// scanning the flattened 256-bit stream once the window closes.
// -----------------------------------------------------------------------------
module tb_output_pattern_monitor;

  localparam int SW     = 4;
  localparam int AW     = 6;
  localparam int BW     = 8;
  localparam int NWORDS = 64;
  localparam int NBITS  = NWORDS * SW;

  logic          evrClk = 1'b0;
  logic          evrRst_n;
  logic          armStrobe;
  logic          triggerStrobe;
  logic [SW-1:0] serdesPattern;
  logic [AW-1:0] captureAddress;
  logic [SW-1:0] captureData;
  logic          busy;
  logic          done;
  logic          edgeFound;
  logic [BW-1:0] firstEdge;
  logic [BW:0]   pulseWidth;
  logic          widthOpen;
  logic [BW-1:0] edgeCount;

  output_pattern_monitor #(
    .SERDES_WIDTH(SW),
    .CAPTURE_ADDRESS_WIDTH(AW)
  ) dut (
    .evrClk        (evrClk),
    .evrRst_n      (evrRst_n),
    .armStrobe     (armStrobe),
    .triggerStrobe (triggerStrobe),
    .serdesPattern (serdesPattern),
    .captureAddress(captureAddress),
    .captureData   (captureData),
    .busy          (busy),
    .done          (done),
    .edgeFound     (edgeFound),
    .firstEdge     (firstEdge),
    .pulseWidth    (pulseWidth),
    .widthOpen     (widthOpen),
    .edgeCount     (edgeCount)
  );

  always #5 evrClk = ~evrClk;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  logic [SW-1:0] rnd_words [128];

  // ---------------------------------------------------------------- model
  logic          m_busy, m_done, m_found, m_open;
  logic [BW-1:0] m_first, m_count;
  logic [BW:0]   m_width;
  bit            m_armed, m_capturing;
  int            m_len;
  logic [SW-1:0] m_words [NWORDS];
  logic [SW-1:0] m_rd_exp;
  bit            m_rd_valid;

  function automatic logic bitAt(input int k);
    logic [SW-1:0] w;
    w = m_words[k / SW];
    return w[k % SW];
  endfunction

  // Evaluate the finished window as one flat bit stream, earliest bit first.
  function automatic void evaluateWindow();
    int   first_rise;
    int   rises;
    int   run;
    int   i;
    logic prev;
    logic cur;
    first_rise = -1;
    rises      = 0;
    prev       = 1'b0;
    for (int k = 0; k < NBITS; k++) begin
      cur = bitAt(k);
      if (cur && !prev) begin
        rises++;
        if (first_rise < 0) first_rise = k;
      end
      prev = cur;
    end
    run = 0;
    i   = NBITS;
    if (first_rise >= 0) begin
      i = first_rise;
      while (i < NBITS && bitAt(i)) begin
        run++;
        i++;
      end
    end
    m_found = (first_rise >= 0);
    m_first = m_found ? BW'(first_rise) : {BW{1'b1}};
    m_width = m_found ? (BW+1)'(run) : '0;
    m_open  = m_found && (i == NBITS);
    m_count = (rises > 255) ? 8'hFF : BW'(rises);
  endfunction

  function automatic void clearResults();
    m_found = 1'b0;
    m_first = '0;
    m_width = '0;
    m_open  = 1'b0;
    m_count = '0;
  endfunction

  always @(posedge evrClk or negedge evrRst_n) begin
    if (!evrRst_n) begin
      m_busy      = 1'b0;
      m_done      = 1'b0;
      m_armed     = 1'b0;
      m_capturing = 1'b0;
      m_len       = 0;
      m_rd_valid  = 1'b0;
      m_rd_exp    = '0;
      clearResults();
    end else begin
      // Buffer reads are checkable only while a completed window is held.
      m_rd_valid = m_done;
      m_rd_exp   = m_words[captureAddress];
      if (armStrobe) begin
        m_armed     = 1'b1;
        m_capturing = 1'b0;
        m_busy      = 1'b1;
        m_done      = 1'b0;
        clearResults();
      end else if (m_armed && triggerStrobe) begin
        m_armed     = 1'b0;
        m_capturing = 1'b1;
        m_words[0]  = serdesPattern;
        m_len       = 1;
      end else if (m_capturing) begin
        m_words[m_len] = serdesPattern;
        m_len++;
        if (m_len == NWORDS) begin
          m_capturing = 1'b0;
          m_busy      = 1'b0;
          m_done      = 1'b1;
          evaluateWindow();
        end
      end
    end
  end

  // ---------------------------------------------------------------- checks
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".busy"},        32'(busy),        0);
    checkOutput({tag, ".done"},        32'(done),        0);
    checkOutput({tag, ".edgeFound"},   32'(edgeFound),   0);
    checkOutput({tag, ".firstEdge"},   32'(firstEdge),   0);
    checkOutput({tag, ".pulseWidth"},  32'(pulseWidth),  0);
    checkOutput({tag, ".widthOpen"},   32'(widthOpen),   0);
    checkOutput({tag, ".edgeCount"},   32'(edgeCount),   0);
    checkOutput({tag, ".captureData"}, 32'(captureData), 0);
  endtask

  task automatic checkResults(input string tag, input int found, input int first,
                              input int width, input int open, input int cnt);
    checkOutput({tag, ".done"},       32'(done),       1);
    checkOutput({tag, ".busy"},       32'(busy),       0);
    checkOutput({tag, ".edgeFound"},  32'(edgeFound),  found);
    checkOutput({tag, ".firstEdge"},  32'(firstEdge),  first);
    checkOutput({tag, ".pulseWidth"}, 32'(pulseWidth), width);
    checkOutput({tag, ".widthOpen"},  32'(widthOpen),  open);
    checkOutput({tag, ".edgeCount"},  32'(edgeCount),  cnt);
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge evrClk) begin
    if (check_en) begin
      if (!evrRst_n) begin
        checkResetOutputs("cyc.reset");
      end else begin
        checkOutput("cyc.busy", 32'(busy), 32'(m_busy));
        checkOutput("cyc.done", 32'(done), 32'(m_done));
        if (!m_capturing) begin
          checkOutput("cyc.edgeFound",  32'(edgeFound),  32'(m_found));
          checkOutput("cyc.firstEdge",  32'(firstEdge),  32'(m_first));
          checkOutput("cyc.pulseWidth", 32'(pulseWidth), 32'(m_width));
          checkOutput("cyc.widthOpen",  32'(widthOpen),  32'(m_open));
          checkOutput("cyc.edgeCount",  32'(edgeCount),  32'(m_count));
        end
        if (m_rd_valid) begin
          checkOutput("cyc.captureData", 32'(captureData), 32'(m_rd_exp));
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  function automatic logic [SW-1:0] patWord(input int kind, input int n);
    case (kind)
      0: case (n % 4)
           0:       return 4'hF;
           1:       return 4'h1;
           default: return 4'h0;
         endcase
      1: begin
        if (n == 3)              return 4'hC;
        if (n >= 4 && n <= 12)   return 4'hF;
        if (n == 13)             return 4'h1;
        return 4'h0;
      end
      2:       return 4'h0;
      3:       return 4'hF;
      default: return rnd_words[n % 128];
    endcase
  endfunction

  task automatic applyStimulus(input logic arm, input logic trig,
                               input logic [SW-1:0] pat, input logic [AW-1:0] addr);
    armStrobe      = arm;
    triggerStrobe  = trig;
    serdesPattern  = pat;
    captureAddress = addr;
    @(posedge evrClk);
    #1;
  endtask

  task automatic armMonitor();
    applyStimulus(1'b1, 1'b0, SW'($urandom), AW'($urandom));
    checkOutput("arm.busy", 32'(busy), 1);
  endtask

  // Trigger, then feed words until done rises or a cycle budget expires.
  task automatic runWindow(input int kind, input bit stray, output int cycles);
    int n;
    applyStimulus(1'b0, 1'b1, patWord(kind, 0), AW'($urandom));
    n = 1;
    while (done !== 1'b1 && n < 100) begin
      applyStimulus(1'b0, stray && ($urandom_range(0, 7) == 0), patWord(kind, n), AW'($urandom));
      n++;
    end
    cycles = n;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int style;
    evrRst_n       = 1'b0;
    armStrobe      = 1'b0;
    triggerStrobe  = 1'b0;
    serdesPattern  = '0;
    captureAddress = '0;
    @(posedge evrClk);
    #1;
    check_en = 1'b1;
    checkResetOutputs("reset");
    repeat (2) @(posedge evrClk);
    #1;
    evrRst_n = 1'b1;

    // Trigger while idle is ignored.
    applyStimulus(1'b0, 1'b1, 4'hF, '0);
    checkOutput("idleTrig.busy", 32'(busy), 0);

    // Looped 16-bit period with 5 ones.
    armMonitor();
    runWindow(0, 1'b0, cyc);
    checkOutput("loop.latency", cyc, 64);
    checkResults("loop", 1, 0, 5, 0, 16);

    // Single long pulse, then buffer readback.
    armMonitor();
    runWindow(1, 1'b0, cyc);
    checkOutput("pulse.latency", cyc, 64);
    checkResults("pulse", 1, 14, 39, 0, 1);
    applyStimulus(1'b0, 1'b0, 4'h0, 6'd3);
    checkOutput("read.addr3", 32'(captureData), 32'hC);
    applyStimulus(1'b0, 1'b0, 4'h0, 6'd13);
    checkOutput("read.addr13", 32'(captureData), 32'h1);

    // All zeros and all ones.
    armMonitor();
    runWindow(2, 1'b0, cyc);
    checkResults("zeros", 0, 255, 0, 0, 0);
    armMonitor();
    runWindow(3, 1'b0, cyc);
    checkResults("ones", 1, 0, 256, 1, 1);

    // Re-arm at capture word 20, then a fresh window.
    armMonitor();
    applyStimulus(1'b0, 1'b1, patWord(0, 0), '0);
    for (int n = 1; n < 20; n++) applyStimulus(1'b0, 1'b0, patWord(0, n), '0);
    applyStimulus(1'b1, 1'b0, patWord(0, 20), '0);
    checkOutput("rearm.done",       32'(done),       0);
    checkOutput("rearm.busy",       32'(busy),       1);
    checkOutput("rearm.edgeFound",  32'(edgeFound),  0);
    checkOutput("rearm.pulseWidth", 32'(pulseWidth), 0);
    checkOutput("rearm.edgeCount",  32'(edgeCount),  0);
    repeat (2) applyStimulus(1'b0, 1'b0, 4'h0, '0);
    runWindow(1, 1'b0, cyc);
    checkOutput("rearm2.latency", cyc, 64);
    checkResults("rearm2", 1, 14, 39, 0, 1);

    // Reset in the middle of a capture.
    armMonitor();
    applyStimulus(1'b0, 1'b1, 4'hF, '0);
    for (int n = 1; n < 10; n++) applyStimulus(1'b0, 1'b0, 4'hF, '0);
    evrRst_n = 1'b0;
    #1;
    checkResetOutputs("midReset");
    repeat (2) @(posedge evrClk);
    #1;
    evrRst_n = 1'b1;

    // Randomised windows with stray triggers and arm/trigger collisions.
    for (int w = 0; w < 10; w++) begin
      style = w % 3;
      for (int j = 0; j < 128; j++) begin
        case (style)
          0:       rnd_words[j] = SW'($urandom);
          1:       rnd_words[j] = ($urandom_range(0, 9) == 0) ? SW'($urandom) : 4'h0;
          default: rnd_words[j] = ($urandom_range(0, 9) == 0) ? SW'($urandom) : 4'hF;
        endcase
      end
      applyStimulus(1'b0, 1'b1, SW'($urandom), AW'($urandom));
      applyStimulus(1'b1, (w % 4 == 1), SW'($urandom), AW'($urandom));
      repeat ($urandom_range(0, 3)) applyStimulus(1'b0, 1'b0, SW'($urandom), AW'($urandom));
      runWindow(4, 1'b1, cyc);
      checkOutput("rand.latency", cyc, 64);
      repeat (6) applyStimulus(1'b0, 1'b0, SW'($urandom), AW'($urandom));
    end

    applyStimulus(1'b0, 1'b0, 4'h0, '0);
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
